// File: rtl/stall_controller.sv
// Pipeline hazard controller: load-use interlock, branch flush, and the
// multdiv start/wait/done handshake with a sticky timeout flag.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | normal flow; flush, mul/div launch or load-use interlock
// MD_START | one-cycle multdiv start pulse, pipeline frozen
// MD_WAIT  | waiting for md_rdy or timeout, pipeline frozen
// MD_DONE  | result steered from multdiv into X, pipeline released
module stall_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_insn,
  input  logic [31:0] dx_insn,
  input  logic        flush_req,
  input  logic        md_rdy,
  output logic        stall_pc,
  output logic        stall_fd,
  output logic        stall_dx,
  output logic        bubble_dx,
  output logic        bubble_xm,
  output logic        flush_fd,
  output logic        flush_dx,
  output logic        md_start,
  output logic        md_is_div,
  output logic        md_result_sel,
  output logic        md_error
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MD_START = 2'd1,
    MD_WAIT  = 2'd2,
    MD_DONE  = 2'd3
  } state_t;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  state_t     state;
  logic [5:0] wait_cnt;

  logic [4:0] dx_op, dx_rd, dx_alu;
  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic       is_md, is_div, load_use;
  logic       rs_reader, rt_reader, rd_reader;
  logic       unused_bits;

  assign dx_op  = dx_insn[31:27];
  assign dx_rd  = dx_insn[26:22];
  assign dx_alu = dx_insn[6:2];
  assign fd_op  = fd_insn[31:27];
  assign fd_rd  = fd_insn[26:22];
  assign fd_rs  = fd_insn[21:17];
  assign fd_rt  = fd_insn[16:12];

  assign unused_bits = ^{dx_insn[21:7], dx_insn[1:0], fd_insn[11:0]};

  assign is_div = (dx_op == OP_ALU) && (dx_alu == ALU_DIV);
  assign is_md  = (dx_op == OP_ALU) && ((dx_alu == ALU_MUL) || (dx_alu == ALU_DIV));

  // Which F/D opcodes actually read rs, rt, or (for branches/stores-by-rd) rd
  always_comb begin
    rs_reader = 1'b0;
    rt_reader = 1'b0;
    rd_reader = 1'b0;
    case (fd_op)
      5'b00000: begin rs_reader = 1'b1; rt_reader = 1'b1; end
      5'b00101, 5'b01000, 5'b00111: rs_reader = 1'b1;
      5'b00010, 5'b00110: begin rs_reader = 1'b1; rd_reader = 1'b1; end
      5'b00100: rd_reader = 1'b1;
      default: ;
    endcase
  end

  assign load_use = (dx_op == OP_LW) && (dx_rd != 5'd0) &&
                    ((rs_reader && (fd_rs == dx_rd)) ||
                     (rt_reader && (fd_rt == dx_rd)) ||
                     (rd_reader && (fd_rd == dx_rd)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= 6'd0;
      md_start  <= 1'b0;
      md_is_div <= 1'b0;
      md_error  <= 1'b0;
    end else begin
      md_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush_req && is_md) begin
            state     <= MD_START;
            md_start  <= 1'b1;
            md_is_div <= is_div;
          end
        end
        MD_START: begin
          wait_cnt <= 6'd0;
          state    <= MD_WAIT;
        end
        MD_WAIT: begin
          wait_cnt <= wait_cnt + 6'd1;
          if (md_rdy) begin
            state <= MD_DONE;
          end else if (wait_cnt == 6'd63) begin
            md_error <= 1'b1;
            state    <= MD_DONE;
          end
        end
        MD_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall_pc      = 1'b0;
    stall_fd      = 1'b0;
    stall_dx      = 1'b0;
    bubble_dx     = 1'b0;
    bubble_xm     = 1'b0;
    flush_fd      = 1'b0;
    flush_dx      = 1'b0;
    md_result_sel = 1'b0;
    case (state)
      IDLE: begin
        if (flush_req) begin
          flush_fd = 1'b1;
          flush_dx = 1'b1;
        end else if (is_md) begin
          stall_pc  = 1'b1;
          stall_fd  = 1'b1;
          stall_dx  = 1'b1;
          bubble_xm = 1'b1;
        end else if (load_use) begin
          stall_pc  = 1'b1;
          stall_fd  = 1'b1;
          bubble_dx = 1'b1;
        end
      end
      MD_START, MD_WAIT: begin
        stall_pc  = 1'b1;
        stall_fd  = 1'b1;
        stall_dx  = 1'b1;
        bubble_xm = 1'b1;
      end
      MD_DONE: md_result_sel = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stall_controller.sv
// Bench for stall_controller: decode vector table, hand-written multdiv
// sequences, then randomized traffic against a cycle-level reference model.
module tb_stall_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] fd_insn, dx_insn;
  logic        flush_req, md_rdy;
  logic        stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm;
  logic        flush_fd, flush_dx, md_start, md_is_div, md_result_sel, md_error;

  stall_controller dut (
    .clock(clock), .reset(reset), .fd_insn(fd_insn), .dx_insn(dx_insn),
    .flush_req(flush_req), .md_rdy(md_rdy),
    .stall_pc(stall_pc), .stall_fd(stall_fd), .stall_dx(stall_dx),
    .bubble_dx(bubble_dx), .bubble_xm(bubble_xm),
    .flush_fd(flush_fd), .flush_dx(flush_dx),
    .md_start(md_start), .md_is_div(md_is_div),
    .md_result_sel(md_result_sel), .md_error(md_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;

  // {stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd, flush_dx}
  localparam logic [6:0] V_NONE  = 7'b0000000;
  localparam logic [6:0] V_LU    = 7'b1101000;
  localparam logic [6:0] V_MD    = 7'b1110100;
  localparam logic [6:0] V_FLUSH = 7'b0000011;
  localparam logic [31:0] NOP    = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] comb_outs();
    return {stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd, flush_dx};
  endfunction

  function automatic logic [31:0] r_type(input int rd, input int rs, input int rt, input int alu);
    return {5'b00000, 5'(rd), 5'(rs), 5'(rt), 5'b00000, 5'(alu), 2'b00};
  endfunction

  function automatic logic [31:0] i_type(input int op, input int rd, input int rs, input int imm);
    return {5'(op), 5'(rd), 5'(rs), 17'(imm)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; fd_insn = NOP; dx_insn = NOP; flush_req = 1'b0; md_rdy = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Reference load-use rule, straight from the hazard definition
  function automatic bit lu_ref(input logic [31:0] fd, input logic [31:0] dx);
    logic [4:0] r, op;
    r  = dx[26:22];
    op = fd[31:27];
    if (dx[31:27] != 5'b01000 || r == 5'd0) return 0;
    if (fd[21:17] == r && op inside {5'b00000, 5'b00101, 5'b01000, 5'b00111, 5'b00010, 5'b00110}) return 1;
    if (fd[16:12] == r && op == 5'b00000) return 1;
    if (fd[26:22] == r && op inside {5'b00010, 5'b00110, 5'b00100}) return 1;
    return 0;
  endfunction

  function automatic bit md_ref(input logic [31:0] dx);
    return dx[31:27] == 5'd0 && (dx[6:2] == 5'd6 || dx[6:2] == 5'd7);
  endfunction

  typedef struct {
    logic [31:0] fd;
    logic [31:0] dx;
    logic        flush;
    logic [6:0]  exp_outs;
    logic        exp_start;
  } vec_t;

  vec_t vecs[14];

  int stall_cnt, sel_cnt, sel_cyc, start_cnt, start_cyc, err_cyc;

  // model state for random phase
  bit m_busy, m_fin, m_div, m_err;
  int m_age;
  logic [6:0] exp_v;
  logic [4:0] ops[9] = '{5'd0, 5'd5, 5'd8, 5'd7, 5'd2, 5'd6, 5'd4, 5'd1, 5'd3};
  logic [4:0] alus[4] = '{5'd0, 5'd6, 5'd7, 5'd5};

  function automatic logic [31:0] rand_insn();
    logic [31:0] x;
    x = $urandom;
    x[31:27] = ops[$urandom_range(0, 8)];
    x[26:22] = 5'($urandom_range(0, 3));
    x[21:17] = 5'($urandom_range(0, 3));
    x[16:12] = 5'($urandom_range(0, 3));
    x[6:2]   = alus[$urandom_range(0, 3)];
    return x;
  endfunction

  initial begin
    vecs[0]  = '{NOP, NOP, 1'b0, V_NONE, 1'b0};
    vecs[1]  = '{r_type(6, 5, 2, 0), i_type(8, 5, 1, 0), 1'b0, V_LU, 1'b0};
    vecs[2]  = '{r_type(6, 0, 2, 0), i_type(8, 0, 1, 0), 1'b0, V_NONE, 1'b0};
    vecs[3]  = '{i_type(7, 7, 4, 0), i_type(8, 7, 1, 0), 1'b0, V_NONE, 1'b0};
    vecs[4]  = '{i_type(2, 7, 1, 3), i_type(8, 7, 1, 0), 1'b0, V_LU, 1'b0};
    vecs[5]  = '{r_type(6, 2, 5, 0), i_type(8, 5, 1, 0), 1'b0, V_LU, 1'b0};
    vecs[6]  = '{i_type(5, 6, 2, 5 << 12), i_type(8, 5, 1, 0), 1'b0, V_NONE, 1'b0};
    vecs[7]  = '{NOP, r_type(3, 1, 2, 6), 1'b0, V_MD, 1'b1};
    vecs[8]  = '{NOP, r_type(3, 1, 2, 7), 1'b1, V_FLUSH, 1'b0};
    vecs[9]  = '{r_type(6, 5, 2, 0), i_type(8, 5, 1, 0), 1'b1, V_FLUSH, 1'b0};
    vecs[10] = '{NOP, r_type(3, 1, 2, 5), 1'b0, V_NONE, 1'b0};
    vecs[11] = '{NOP, i_type(1, 0, 0, 6 << 2), 1'b0, V_NONE, 1'b0};
    vecs[12] = '{i_type(1, 5, 0, 0), i_type(8, 5, 1, 0), 1'b0, V_NONE, 1'b0};
    vecs[13] = '{i_type(6, 5, 3, 0), i_type(8, 5, 1, 0), 1'b0, V_LU, 1'b0};

    reset = 1'b1; fd_insn = NOP; dx_insn = NOP; flush_req = 1'b0; md_rdy = 1'b0;
    tick(); tick();
    check("reset_comb", 32'(comb_outs()), 32'(V_NONE));
    check("reset_regs", {28'd0, md_start, md_is_div, md_result_sel, md_error}, 32'd0);

    foreach (vecs[i]) begin
      do_reset();
      fd_insn = vecs[i].fd; dx_insn = vecs[i].dx; flush_req = vecs[i].flush;
      #1;
      check($sformatf("vec%0d_outs", i), 32'(comb_outs()), 32'(vecs[i].exp_outs));
      check($sformatf("vec%0d_sel", i), 32'(md_result_sel), 32'd0);
      tick();
      check($sformatf("vec%0d_start", i), 32'(md_start), 32'(vecs[i].exp_start));
    end

    // mul, md_rdy in the 20th wait cycle
    do_reset();
    stall_cnt = 0; sel_cnt = 0; sel_cyc = -1; start_cnt = 0; start_cyc = -1;
    for (int c = 0; c < 30; c++) begin
      dx_insn = (c <= 21) ? r_type(3, 1, 2, 6) : NOP;
      md_rdy  = (c == 21);
      #1;
      if (stall_pc && stall_fd && stall_dx) stall_cnt++;
      if (md_result_sel) begin sel_cnt++; sel_cyc = c; end
      if (md_start) begin start_cnt++; start_cyc = c; end
      if (c == 1) check("mul_is_div", 32'(md_is_div), 32'd0);
      tick();
    end
    check("mul_stall_cycles", stall_cnt, 22);
    check("mul_start_count", start_cnt, 1);
    check("mul_start_cycle", start_cyc, 1);
    check("mul_sel_count", sel_cnt, 1);
    check("mul_sel_cycle", sel_cyc, 22);
    check("mul_error", 32'(md_error), 32'd0);

    // div, md_rdy never arrives -> timeout after 64 wait cycles
    do_reset();
    stall_cnt = 0; sel_cyc = -1; err_cyc = -1;
    for (int c = 0; c < 76; c++) begin
      dx_insn = (c <= 65) ? r_type(4, 1, 2, 7) : NOP;
      #1;
      if (stall_pc && stall_fd && stall_dx) stall_cnt++;
      if (md_result_sel) sel_cyc = c;
      if (md_error && err_cyc < 0) err_cyc = c;
      if (c == 1) check("div_is_div", 32'(md_is_div), 32'd1);
      tick();
    end
    check("div_stall_cycles", stall_cnt, 66);
    check("div_error_cycle", err_cyc, 66);
    check("div_sel_cycle", sel_cyc, 66);
    check("div_error_sticky", 32'(md_error), 32'd1);

    // flush beats a mul in dx
    do_reset();
    dx_insn = r_type(3, 1, 2, 6); flush_req = 1'b1;
    #1;
    check("flush_mul_outs", 32'(comb_outs()), 32'(V_FLUSH));
    tick();
    check("flush_mul_start", 32'(md_start), 32'd0);
    flush_req = 1'b0; dx_insn = NOP;
    #1;
    check("flush_mul_idle", 32'(comb_outs()), 32'(V_NONE));

    // reset while in MD_WAIT
    do_reset();
    dx_insn = r_type(3, 1, 2, 7);
    tick(); tick();
    check("rst_wait_stalled", 32'(comb_outs()), 32'(V_MD));
    reset = 1'b1;
    tick();
    reset = 1'b0; dx_insn = NOP;
    #1;
    check("rst_wait_comb", 32'(comb_outs()), 32'(V_NONE));
    check("rst_wait_regs", {28'd0, md_start, md_is_div, md_result_sel, md_error}, 32'd0);

    // randomized traffic against the reference model
    do_reset();
    m_busy = 0; m_fin = 0; m_div = 0; m_err = 0; m_age = 0;
    for (int n = 0; n < 4000; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      flush_req = ($urandom_range(0, 9) == 0);
      md_rdy    = ($urandom_range(0, 24) == 0);
      fd_insn   = rand_insn();
      case ($urandom_range(0, 5))
        0, 1:    dx_insn = i_type(8, $urandom_range(0, 3), 1, 0);
        2:       dx_insn = r_type(1, 2, 3, $urandom_range(6, 7));
        default: dx_insn = rand_insn();
      endcase
      #1;
      if (m_fin)       exp_v = V_NONE;
      else if (m_busy) exp_v = V_MD;
      else if (flush_req) exp_v = V_FLUSH;
      else if (md_ref(dx_insn)) exp_v = V_MD;
      else if (lu_ref(fd_insn, dx_insn)) exp_v = V_LU;
      else exp_v = V_NONE;
      check("rnd_outs", 32'(comb_outs()), 32'(exp_v));
      check("rnd_sel", 32'(md_result_sel), 32'(m_fin));
      check("rnd_start", 32'(md_start), 32'(m_busy && !m_fin && m_age == 1));
      check("rnd_is_div", 32'(md_is_div), 32'(m_div));
      check("rnd_error", 32'(md_error), 32'(m_err));
      if (reset) begin
        m_busy = 0; m_fin = 0; m_div = 0; m_err = 0; m_age = 0;
      end else if (m_fin) begin
        m_fin = 0; m_busy = 0;
      end else if (m_busy) begin
        if (m_age >= 2 && (md_rdy || m_age - 1 == 64)) begin
          m_fin = 1;
          if (!md_rdy) m_err = 1;
        end
        m_age++;
      end else if (!flush_req && md_ref(dx_insn)) begin
        m_busy = 1; m_age = 1; m_div = (dx_insn[6:2] == 5'd7);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
